// File: rtl/riscv_pkg.sv
// Shared encodings for the RISC-V MEM stage: funct3 access types,
// writeback-source selects and the MEM-stage FSM state type.
package riscv_pkg;

  // funct3 data-memory access types
  localparam logic [2:0] DM_B  = 3'b000;
  localparam logic [2:0] DM_H  = 3'b001;
  localparam logic [2:0] DM_W  = 3'b010;
  localparam logic [2:0] DM_BU = 3'b100;
  localparam logic [2:0] DM_HU = 3'b101;

  // writeback source select (controlRF)
  localparam logic [1:0] CRF_ALU = 2'b00;
  localparam logic [1:0] CRF_MEM = 2'b01;
  localparam logic [1:0] CRF_PC4 = 2'b10;
  localparam logic [1:0] CRF_IMM = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mem_state_e;

  // Map an arbitrary funct3 onto a supported access type; anything
  // unsupported behaves as a full word. Stores have no unsigned forms.
  function automatic logic [2:0] dm_normalize(input logic [2:0] t, input logic is_store);
    logic [2:0] r;
    r = DM_W;
    if (is_store) begin
      if ((t == DM_B) || (t == DM_H) || (t == DM_W)) r = t;
    end else begin
      if ((t == DM_B) || (t == DM_H) || (t == DM_W) || (t == DM_BU) || (t == DM_HU)) r = t;
    end
    return r;
  endfunction

endpackage

// File: rtl/load_align_ext.sv
// Picks the addressed byte/half out of a 32-bit read word and sign- or
// zero-extends it according to the access type.
import riscv_pkg::*;

module load_align_ext (
  input  logic [31:0] word_in,
  input  logic [1:0]  offset_in,
  input  logic [2:0]  type_in,
  output logic [31:0] data_out
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // lane select followed by extension
  always_comb begin
    case (offset_in)
      2'd0:    byte_sel = word_in[7:0];
      2'd1:    byte_sel = word_in[15:8];
      2'd2:    byte_sel = word_in[23:16];
      default: byte_sel = word_in[31:24];
    endcase
    half_sel = offset_in[1] ? word_in[31:16] : word_in[15:0];
    case (type_in)
      DM_B:    data_out = {{24{byte_sel[7]}}, byte_sel};
      DM_H:    data_out = {{16{half_sel[15]}}, half_sel};
      DM_BU:   data_out = {24'd0, byte_sel};
      DM_HU:   data_out = {16'd0, half_sel};
      default: data_out = word_in;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: issues loads/stores on a valid/ready data bus, stalls the
// upstream pipe while an access is outstanding, and registers MEM/WB.
//
// Bus handshake: bus_req is a registered valid. Once raised, bus_req and
// every bus_* output stay constant until a cycle where bus_ready is high;
// that cycle completes the access (bus_rdata is sampled then) and bus_req
// drops on the following edge. If TIMEOUT busy cycles pass without
// bus_ready, the access is abandoned and flagged with bus_err_out.
import riscv_pkg::*;

module mem_access_stage #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       result_in,
  input  logic [31:0]       data2_in,
  input  logic [31:0]       sum_out_in,
  input  logic [31:0]       imm_in,
  input  logic [4:0]        rd_in,
  input  logic              we_in,
  input  logic [1:0]        controlRF_in,
  input  logic [2:0]        Type_dm_in,
  input  logic              load_in,
  input  logic              store_in,
  output logic              stall,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_wdata,
  output logic [3:0]        bus_wstrb,
  input  logic              bus_ready,
  input  logic [31:0]       bus_rdata,
  output logic [31:0]       rdata_out,
  output logic [31:0]       result_out,
  output logic [31:0]       sum_out_out,
  output logic [31:0]       imm_out,
  output logic [4:0]        rd_out,
  output logic              we_out,
  output logic [1:0]        controlRF_out,
  output logic              misalign_out,
  output logic              bus_err_out,
  output mem_state_e        state_dbg
);

  localparam int CNT_W = $clog2(TIMEOUT);

  mem_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_we_q, bus_we_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [31:0]       bus_wdata_q, bus_wdata_d;
  logic [3:0]        bus_wstrb_q, bus_wstrb_d;
  logic [2:0]        type_q, type_d;
  logic [1:0]        off_q, off_d;
  logic              is_load_q, is_load_d;

  logic [31:0] rdata_q, rdata_d, result_q, result_d, sum_q, sum_d, imm_q, imm_d;
  logic [4:0]  rd_q, rd_d;
  logic        we_q, we_d, misalign_q, misalign_d, bus_err_q, bus_err_d;
  logic [1:0]  crf_q, crf_d;

  logic [2:0]  type_eff;
  logic        mem_op, misaligned;
  logic [3:0]  st_wstrb;
  logic [31:0] st_wdata;
  logic [31:0] load_fmt;
  logic        stall_c;

  load_align_ext u_align (
    .word_in   (bus_rdata),
    .offset_in (off_q),
    .type_in   (type_q),
    .data_out  (load_fmt)
  );

  // decode access type, alignment and store lane placement
  always_comb begin
    type_eff   = dm_normalize(Type_dm_in, store_in);
    mem_op     = load_in | store_in;
    misaligned = mem_op &
                 (((type_eff[1:0] == 2'b01) & result_in[0]) |
                  ((type_eff[1:0] == 2'b10) & (result_in[1:0] != 2'b00)));
    case (type_eff[1:0])
      2'b00: begin
        st_wstrb = 4'b0001 << result_in[1:0];
        st_wdata = {4{data2_in[7:0]}};
      end
      2'b01: begin
        st_wstrb = result_in[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{data2_in[15:0]}};
      end
      default: begin
        st_wstrb = 4'b1111;
        st_wdata = data2_in;
      end
    endcase
  end

  // next-state, bus and MEM/WB computation
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_wstrb_d = bus_wstrb_q;
    type_d      = type_q;
    off_d       = off_q;
    is_load_d   = is_load_q;
    stall_c     = 1'b0;
    // MEM/WB defaults to a bubble
    rdata_d     = '0;
    result_d    = '0;
    sum_d       = '0;
    imm_d       = '0;
    rd_d        = '0;
    we_d        = 1'b0;
    crf_d       = '0;
    misalign_d  = 1'b0;
    bus_err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (mem_op && !misaligned) begin
          stall_c     = 1'b1;
          state_d     = ST_BUSY;
          cnt_d       = '0;
          bus_req_d   = 1'b1;
          bus_we_d    = store_in;
          bus_addr_d  = {result_in[ADDR_W-1:2], 2'b00};
          bus_wdata_d = store_in ? st_wdata : 32'd0;
          bus_wstrb_d = store_in ? st_wstrb : 4'b0000;
          type_d      = type_eff;
          off_d       = result_in[1:0];
          is_load_d   = ~store_in;
        end else begin
          result_d   = result_in;
          sum_d      = sum_out_in;
          imm_d      = imm_in;
          rd_d       = rd_in;
          crf_d      = controlRF_in;
          we_d       = we_in & ~misaligned;
          misalign_d = misaligned;
        end
      end
      ST_BUSY: begin
        if (bus_ready || (cnt_q == CNT_W'(TIMEOUT - 1))) begin
          // completion or abandonment: upstream was frozen, so the inputs
          // still describe the instruction that owns this access
          result_d    = result_in;
          sum_d       = sum_out_in;
          imm_d       = imm_in;
          rd_d        = rd_in;
          crf_d       = controlRF_in;
          we_d        = bus_ready & we_in;
          rdata_d     = (bus_ready && is_load_q) ? load_fmt : 32'd0;
          bus_err_d   = ~bus_ready;
          state_d     = ST_IDLE;
          cnt_d       = '0;
          bus_req_d   = 1'b0;
          bus_we_d    = 1'b0;
          bus_addr_d  = '0;
          bus_wdata_d = '0;
          bus_wstrb_d = '0;
        end else begin
          stall_c = 1'b1;
          cnt_d   = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // state, bus and MEM/WB registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_wstrb_q <= '0;
      type_q      <= '0;
      off_q       <= '0;
      is_load_q   <= 1'b0;
      rdata_q     <= '0;
      result_q    <= '0;
      sum_q       <= '0;
      imm_q       <= '0;
      rd_q        <= '0;
      we_q        <= 1'b0;
      crf_q       <= '0;
      misalign_q  <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_wstrb_q <= bus_wstrb_d;
      type_q      <= type_d;
      off_q       <= off_d;
      is_load_q   <= is_load_d;
      rdata_q     <= rdata_d;
      result_q    <= result_d;
      sum_q       <= sum_d;
      imm_q       <= imm_d;
      rd_q        <= rd_d;
      we_q        <= we_d;
      crf_q       <= crf_d;
      misalign_q  <= misalign_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign stall         = stall_c;
  assign bus_req       = bus_req_q;
  assign bus_we        = bus_we_q;
  assign bus_addr      = bus_addr_q;
  assign bus_wdata     = bus_wdata_q;
  assign bus_wstrb     = bus_wstrb_q;
  assign rdata_out     = rdata_q;
  assign result_out    = result_q;
  assign sum_out_out   = sum_q;
  assign imm_out       = imm_q;
  assign rd_out        = rd_q;
  assign we_out        = we_q;
  assign controlRF_out = crf_q;
  assign misalign_out  = misalign_q;
  assign bus_err_out   = bus_err_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed scenarios followed by random
// ALU/load/store traffic against a byte-lane reference model.
import riscv_pkg::*;

module tb_mem_access_stage;

  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] result_in = '0, data2_in = '0, sum_out_in = '0, imm_in = '0;
  logic [4:0]  rd_in = '0;
  logic        we_in = 1'b0;
  logic [1:0]  controlRF_in = '0;
  logic [2:0]  Type_dm_in = '0;
  logic        load_in = 1'b0, store_in = 1'b0;
  logic        bus_ready = 1'b0;
  logic [31:0] bus_rdata = '0;

  logic        stall, bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;
  logic [31:0] rdata_out, result_out, sum_out_out, imm_out;
  logic [4:0]  rd_out;
  logic        we_out, misalign_out, bus_err_out;
  logic [1:0]  controlRF_out;
  mem_state_e  state_dbg;

  int n_pass = 0;
  int n_total = 0;
  int n_fail = 0;

  mem_access_stage #(.ADDR_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .result_in(result_in), .data2_in(data2_in),
    .sum_out_in(sum_out_in), .imm_in(imm_in), .rd_in(rd_in), .we_in(we_in),
    .controlRF_in(controlRF_in), .Type_dm_in(Type_dm_in), .load_in(load_in),
    .store_in(store_in), .stall(stall), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
    .bus_ready(bus_ready), .bus_rdata(bus_rdata), .rdata_out(rdata_out),
    .result_out(result_out), .sum_out_out(sum_out_out), .imm_out(imm_out),
    .rd_out(rd_out), .we_out(we_out), .controlRF_out(controlRF_out),
    .misalign_out(misalign_out), .bus_err_out(bus_err_out), .state_dbg(state_dbg)
  );

  // clock
  always #5 clk = ~clk;

  // run-time bound
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [2:0] m_type(input logic st, input logic [2:0] t);
    if (st) return (t <= 3'd2) ? t : 3'd2;
    return ((t <= 3'd2) || (t == 3'd4) || (t == 3'd5)) ? t : 3'd2;
  endfunction

  function automatic int m_size(input logic [2:0] t);
    if ((t == 3'd0) || (t == 3'd4)) return 1;
    if ((t == 3'd1) || (t == 3'd5)) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] w, input int off, input logic [2:0] t);
    int sz;
    longint v;
    sz = m_size(t);
    if (sz == 4) return w;
    v = longint'(w >> (8 * off)) & ((64'sd1 <<< (8 * sz)) - 1);
    if ((t < 3'd4) && (v >= (64'sd1 <<< (8 * sz - 1)))) v = v - (64'sd1 <<< (8 * sz));
    return v[31:0];
  endfunction

  // {strobes, write data}: every lane carries data byte (lane mod size)
  function automatic logic [35:0] m_store(input logic [31:0] d, input int off, input int sz);
    logic [31:0] wd;
    logic [3:0]  sb;
    for (int i = 0; i < 4; i++) begin
      wd[8*i +: 8] = d[8*(i % sz) +: 8];
      sb[i] = (i >= off) && (i < off + sz);
    end
    return {sb, wd};
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_rdata"}, rdata_out, 0);
    check({tag, "_result"}, result_out, 0);
    check({tag, "_sum"}, sum_out_out, 0);
    check({tag, "_imm"}, imm_out, 0);
    check({tag, "_rd"}, {27'd0, rd_out}, 0);
    check({tag, "_we"}, {31'd0, we_out}, 0);
    check({tag, "_crf"}, {30'd0, controlRF_out}, 0);
    check({tag, "_mis"}, {31'd0, misalign_out}, 0);
    check({tag, "_err"}, {31'd0, bus_err_out}, 0);
    check({tag, "_req"}, {31'd0, bus_req}, 0);
    check({tag, "_bwe"}, {31'd0, bus_we}, 0);
    check({tag, "_addr"}, bus_addr, 0);
    check({tag, "_wdata"}, bus_wdata, 0);
    check({tag, "_wstrb"}, {28'd0, bus_wstrb}, 0);
    check({tag, "_state"}, {31'd0, state_dbg == ST_IDLE ? 1'b0 : 1'b1}, 0);
  endtask

  // One instruction through MEM, starting at a negedge. waits = number of
  // BUSY cycles with ready low before the ready cycle (>= TO: never ready).
  task automatic run_op(input logic ld, input logic st, input logic [2:0] t,
                        input logic [31:0] addr, input logic [31:0] d2,
                        input logic [31:0] rdw, input int waits,
                        output int n_stall, output logic [31:0] got_rd);
    logic [2:0]  te;
    int          sz, off;
    logic        mem, mis, last, tmo;
    logic [35:0] sw;
    logic [31:0] exp_rd;
    logic        e_we;
    logic [31:0] e_sum, e_imm;
    logic [4:0]  e_rd;
    logic [1:0]  e_crf;
    e_sum = $urandom; e_imm = $urandom; e_rd = 5'($urandom_range(0, 31));
    e_we = 1'($urandom_range(0, 1)) | ~(ld | st); e_crf = 2'($urandom_range(0, 3));
    result_in = addr; data2_in = d2; sum_out_in = e_sum; imm_in = e_imm;
    rd_in = e_rd; we_in = e_we; controlRF_in = e_crf; Type_dm_in = t;
    load_in = ld; store_in = st; bus_ready = 1'b0; bus_rdata = $urandom;
    mem = ld | st;
    te = m_type(st, t);
    sz = m_size(te);
    off = int'(addr[1:0]);
    mis = mem && ((off % sz) != 0);
    sw = m_store(d2, off, sz);
    exp_rd = m_load(rdw, off, te);
    n_stall = 0;
    tmo = 1'b0;
    #1;
    if (!mem || mis) begin
      check("idle_stall", {31'd0, stall}, 0);
      @(posedge clk); @(negedge clk);
      check("pass_misalign", {31'd0, misalign_out}, {31'd0, mis});
      check("pass_we", {31'd0, we_out}, {31'd0, e_we & ~mis});
      check("pass_req", {31'd0, bus_req}, 0);
    end else begin
      check("issue_stall", {31'd0, stall}, 1);
      n_stall++;
      @(posedge clk); @(negedge clk);
      for (int c = 0; c < TO; c++) begin
        bus_ready = (c == waits);
        bus_rdata = (c == waits) ? rdw : $urandom;
        last = (c == waits) || (c == TO - 1);
        #1;
        if (!bus_ready && (c == TO - 1)) tmo = 1'b1;
        check("busy_req", {31'd0, bus_req}, 1);
        check("busy_addr", bus_addr, addr & 32'hFFFF_FFFC);
        check("busy_bwe", {31'd0, bus_we}, {31'd0, st});
        check("busy_wstrb", {28'd0, bus_wstrb}, st ? {28'd0, sw[35:32]} : 0);
        if (st) check("busy_wdata", bus_wdata, sw[31:0]);
        check("busy_bubble_we", {31'd0, we_out}, 0);
        check("busy_stall", {31'd0, stall}, {31'd0, ~last});
        if (stall) n_stall++;
        @(posedge clk); @(negedge clk);
        if (last) break;
      end
      bus_ready = 1'b0;
      check("done_req", {31'd0, bus_req}, 0);
      check("done_we", {31'd0, we_out}, {31'd0, e_we & ~tmo});
      check("done_rdata", rdata_out, (tmo || st) ? 32'd0 : exp_rd);
      check("done_err", {31'd0, bus_err_out}, {31'd0, tmo});
      check("done_misalign", {31'd0, misalign_out}, 0);
    end
    check("out_result", result_out, addr);
    check("out_sum", sum_out_out, e_sum);
    check("out_imm", imm_out, e_imm);
    check("out_rd", {27'd0, rd_out}, {27'd0, e_rd});
    check("out_crf", {30'd0, controlRF_out}, {30'd0, e_crf});
    got_rd = rdata_out;
  endtask

  task automatic idle_inputs();
    result_in = '0; data2_in = '0; sum_out_in = '0; imm_in = '0; rd_in = '0;
    we_in = 1'b0; controlRF_in = '0; Type_dm_in = '0; load_in = 1'b0; store_in = 1'b0;
  endtask

  // directed steps followed by random traffic
  initial begin
    int ns;
    logic [31:0] rd;
    logic ld, st;
    // reset
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    check("reset_stall", {31'd0, stall}, 0);
    rst = 1'b0;

    // ALU pass-through
    run_op(1'b0, 1'b0, 3'd0, 32'h1234, 32'h0, 32'h0, 0, ns, rd);
    check("alu_stall_cnt", ns, 0);
    check("alu_rdata", rd, 0);

    // SB at 0x103, ready on first BUSY cycle
    run_op(1'b0, 1'b1, DM_B, 32'h103, 32'hAABBCCDD, 32'h0, 0, ns, rd);
    check("sb_stall_cnt", ns, 1);

    // loads at 0x202 with three wait cycles each
    run_op(1'b1, 1'b0, DM_B, 32'h202, 32'h0, 32'h80F17F00, 3, ns, rd);
    check("lb_val", rd, 32'hFFFFFFF1);
    check("lb_stall_cnt", ns, 4);
    run_op(1'b1, 1'b0, DM_BU, 32'h202, 32'h0, 32'h80F17F00, 3, ns, rd);
    check("lbu_val", rd, 32'h000000F1);
    run_op(1'b1, 1'b0, DM_H, 32'h202, 32'h0, 32'h80F17F00, 3, ns, rd);
    check("lh_val", rd, 32'hFFFF80F1);
    run_op(1'b1, 1'b0, DM_HU, 32'h202, 32'h0, 32'h80F17F00, 3, ns, rd);
    check("lhu_val", rd, 32'h000080F1);
    check("lhu_stall_cnt", ns, 4);
    run_op(1'b1, 1'b0, DM_W, 32'h200, 32'h0, 32'h80F17F00, 3, ns, rd);
    check("lw_val", rd, 32'h80F17F00);

    // misaligned LW: no bus access, flagged for one slot
    run_op(1'b1, 1'b0, DM_W, 32'h102, 32'h0, 32'h0, 0, ns, rd);
    check("mis_stall_cnt", ns, 0);
    run_op(1'b0, 1'b0, 3'd0, 32'h55, 32'h0, 32'h0, 0, ns, rd);
    check("mis_one_slot", {31'd0, misalign_out}, 0);

    // timeout
    run_op(1'b1, 1'b0, DM_W, 32'h400, 32'h0, 32'h0, 1000, ns, rd);
    check("tmo_stall_cnt", ns, TO);
    run_op(1'b0, 1'b0, 3'd0, 32'h66, 32'h0, 32'h0, 0, ns, rd);
    check("err_one_slot", {31'd0, bus_err_out}, 0);

    // reset on the second BUSY cycle, then a stray ready
    result_in = 32'h300; load_in = 1'b1; Type_dm_in = DM_W; we_in = 1'b1;
    rd_in = 5'd7; bus_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    check("rst_busy1_req", {31'd0, bus_req}, 1);
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    check_all_zero("midrst");
    bus_ready = 1'b1; bus_rdata = 32'hDEADBEEF;
    #1;
    check("stray_stall", {31'd0, stall}, 0);
    @(posedge clk); @(negedge clk);
    bus_ready = 1'b0;
    check_all_zero("stray");
    run_op(1'b0, 1'b0, 3'd0, 32'h1234, 32'h0, 32'h0, 0, ns, rd);

    // random traffic, back to back
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0:       begin ld = 1'b0; st = 1'b0; end
        1:       begin ld = 1'b1; st = 1'b0; end
        2:       begin ld = 1'b0; st = 1'b1; end
        default: begin ld = 1'b1; st = 1'b1; end
      endcase
      run_op(ld, st, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
             $urandom_range(0, 4), ns, rd);
    end

    idle_inputs();
    @(posedge clk); @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM stage of the 5-stage RISC-V pipeline. It consumes the EX/MEM register outputs and performs loads and stores over a valid/ready data-memory bus.
- It formats load data (byte/half/word, signed/unsigned) and stalls upstream stages while a bus access is outstanding.
- Its output is the registered MEM/WB bundle.

Parameters:
- ADDR_W, 32, width of bus address driven from the ALU result.
- TIMEOUT, 64, maximum BUSY cycles before an access is aborted; must be ≥ 2.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- result_in  in  32  ALU result: memory address, or writeback value for non-memory ops.
- data2_in  in  32  rs2 value; store data.
- sum_out_in  in  32  PC+4; passed through.
- imm_in  in  32  immediate; passed through.
- rd_in  in  5  destination register.
- we_in  in  1  register-file write enable.
- controlRF_in  in  2  writeback source select; passed through.
- Type_dm_in  in  3  funct3 access type.
- load_in  in  1  load instruction.
- store_in  in  1  store instruction.
- stall  out  1  freeze PC/IF/ID/EX/EXMEM this cycle; combinational.
- bus_req  out  1  access valid; registered.
- bus_we  out  1  1 = write.
- bus_addr  out  ADDR_W  word-aligned address (low two bits zero).
- bus_wdata  out  32  store data replicated into the target lanes.
- bus_wstrb  out  4  byte-lane enables.
- bus_ready  in  1  access accepted/completed this cycle.
- bus_rdata  in  32  read word; valid when bus_ready is high.
- rdata_out  out  32  formatted load data.
- result_out, sum_out_out, imm_out  out  32  registered pass-through.
- rd_out  out  5; we_out  out  1; controlRF_out  out  2  registered pass-through.
- misalign_out  out  1  registered; the instruction in MEM/WB was misaligned.
- bus_err_out  out  1  registered; the access timed out.

Behaviour:
- Reset: every output is 0; state is IDLE; the wait counter is 0. Reset applies even mid-BUSY. After reset, a bus_ready arriving in IDLE is ignored.
- Type_dm encodings:
  - 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - For stores, only 000/001/010 are valid.
  - Any other code on a memory op is treated as LW/SW.
- Alignment: misaligned = (half and addr[0]) or (word and addr[1:0] ≠ 0).
  - A misaligned op issues no bus access.
  - It passes to MEM/WB in 1 cycle with we_out=0 and misalign_out=1.
- Store lanes:
  - SB: wstrb = 1 << addr[1:0]; byte replicated ×4.
  - SH: wstrb = 0011 or 1100 by addr[1]; half replicated ×2.
  - SW: wstrb = 1111.
  - Loads drive wstrb = 0000.
- FSM states: IDLE, BUSY.
  - IDLE, no aligned memory op: stall=0. The MEM/WB register captures the inputs; rdata_out=0. Latency is 1 cycle.
  - IDLE, aligned load/store: stall=1. Latch address, wdata, wstrb, bus_we, Type_dm and addr[1:0]. Next state BUSY with bus_req=1 and counter=0. MEM/WB captures a bubble (we_out=0, all else 0).
  - BUSY, bus_ready=0: stall=1; bus_req and all bus_* outputs are held stable; counter increments; MEM/WB captures a bubble.
  - BUSY, bus_ready=1: stall=0; bus_req drops next cycle; state returns to IDLE. MEM/WB captures the EX/MEM inputs (unchanged, since upstream was frozen) plus formatted rdata (0 for stores).
  - BUSY, counter = TIMEOUT−1 with no ready: treat as done with rdata=0, we_out=0, bus_err_out=1; state returns to IDLE.
  - Minimum memory-op latency is 2 cycles (IDLE cycle + a BUSY cycle with ready).
- Load format: select the byte/half by the latched addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word unchanged.
- load_in and store_in both high: treat as a store.
- Back-to-back memory ops: the second is detected in the IDLE cycle right after completion; there are no dead bus cycles beyond that IDLE cycle.
- misalign_out and bus_err_out are each held for exactly one MEM/WB slot.

Decomposition:
- riscv_pkg holds:
  - Type_dm encoding constants (DM_B, DM_H, DM_W, DM_BU, DM_HU).
  - controlRF encodings.
  - The FSM state typedef.
- One combinational sub-module, load_align_ext (word + offset + type → 32-bit result), reused by any future cache path.

Test Plan:
- ALU op: result_in=0x1234, we_in=1, no load/store → next edge: result_out=0x1234, we_out=1, stall never high, bus_req=0.
- SB at 0x103, data2=0xAABBCCDD, ready on the 1st BUSY cycle → bus_addr=0x100, wstrb=1000, wdata=0xDDDDDDDD, stall high exactly 1 cycle, we_out=0.
- LB/LBU/LH/LHU/LW at 0x202 with rdata=0x80F17F00, 3 wait cycles each:
  - Results: LB→0xFFFFFFF1, LBU→0x000000F1, LH→0xFFFF80F1, LHU→0x000080F1.
  - LW at 0x200 → 0x80F17F00.
  - stall is high for 4 cycles on each access.
- LW at 0x102 → no bus_req; misalign_out=1, we_out=0 one cycle later.
- Timeout: hold ready=0 → bus_err_out=1 after TIMEOUT BUSY cycles, stall released, we_out=0.
- Reset asserted on the 2nd BUSY cycle, then a late bus_ready pulse → all outputs 0, FSM in IDLE, pulse ignored, next ALU op passes normally.
